// File: rtl/param_fifo.sv
// Synchronous FIFO with count-derived status flags, sticky over/underflow and flush.
// Read latency 1 cycle (FWFT=0) or 0 (FWFT=1); writes to a full FIFO are refused unless a read frees a slot.
module param_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_evt;
  logic             unf_evt;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign rd_acc  = rd_en && !empty && !flush;
  assign wr_acc  = wr_en && (!full || rd_acc) && !flush;
  assign ovf_evt = wr_en && full && !rd_acc && !flush;
  assign unf_evt = rd_en && empty && !flush;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_acc) begin
        rptr <= rptr + AW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CW'(1);
      end
    end
  end

  // A fresh error event outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt || (overflow && !clr_err);
      underflow <= unf_evt || (underflow && !clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata = mem[rptr];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdata_q <= '0;
        end else if (rd_acc) begin
          rdata_q <= mem[rptr];
        end
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule
